// File: rtl/alarm_pkg.sv
// Shared alarm definitions: state encoding, default cycle counts and state decode
// helpers used by the trigger controller and the alarm driver top level.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED   = 3'd0,
    ST_EXIT_WAIT  = 3'd1,
    ST_ARMED      = 3'd2,
    ST_ENTRY_WAIT = 3'd3,
    ST_ALARM      = 3'd4
  } alarm_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYC = 500_000;
  localparam int unsigned DEF_EXIT_CYC     = 250_000_000;
  localparam int unsigned DEF_ENTRY_CYC    = 500_000_000;
  localparam int unsigned DEF_TW           = 29;

  // Unused encodings decode as not armed so a corrupted state never reads as protected.
  function automatic logic state_is_armed(input alarm_state_e s);
    logic r;
    case (s)
      ST_EXIT_WAIT, ST_ARMED, ST_ENTRY_WAIT, ST_ALARM: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer: the output follows
// the synchronized input only after it has differed for DEBOUNCE_CYC consecutive cycles.
module input_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;

  // Synchronize, then count consecutive disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= '0;
      deb     <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r != deb) begin
        if (cnt_r == CW'(DEBOUNCE_CYC - 1)) begin
          deb   <= sync2_r;
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/alarm_trigger_ctrl.sv
// Arming/trigger controller: debounced sensor and buttons drive an exit-delay,
// armed, entry-delay and alarm state machine whose decoded state feeds the alarm driver.
module alarm_trigger_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned EXIT_CYC     = DEF_EXIT_CYC,
  parameter int unsigned ENTRY_CYC    = DEF_ENTRY_CYC,
  parameter int unsigned TW           = DEF_TW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_in,
  input  logic       arm_btn,
  input  logic       disarm_btn,
  output logic       alarm_data,
  output logic       armed,
  output logic       entry_pending,
  output logic [2:0] state_o
);

  logic          sensor_deb_s;
  logic          arm_deb_s;
  logic          disarm_deb_s;
  logic          arm_prev_r;
  logic          disarm_prev_r;
  logic          arm_rise_r;
  logic          disarm_rise_r;
  alarm_state_e  state_r;
  alarm_state_e  state_next_s;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_next_s;

  input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_sensor (
    .clk(clk), .rst_n(rst_n), .raw(sensor_in),  .deb(sensor_deb_s)
  );
  input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_arm (
    .clk(clk), .rst_n(rst_n), .raw(arm_btn),    .deb(arm_deb_s)
  );
  input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_disarm (
    .clk(clk), .rst_n(rst_n), .raw(disarm_btn), .deb(disarm_deb_s)
  );

  // Registered rising-edge pulses so a held button produces exactly one request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_prev_r    <= 1'b0;
      disarm_prev_r <= 1'b0;
      arm_rise_r    <= 1'b0;
      disarm_rise_r <= 1'b0;
    end else begin
      arm_prev_r    <= arm_deb_s;
      disarm_prev_r <= disarm_deb_s;
      arm_rise_r    <= arm_deb_s & ~arm_prev_r;
      disarm_rise_r <= disarm_deb_s & ~disarm_prev_r;
    end
  end

  // Next-state and timer logic; disarm overrides every other transition.
  always_comb begin
    state_next_s = state_r;
    timer_next_s = timer_r;
    if (disarm_rise_r) begin
      state_next_s = ST_DISARMED;
      timer_next_s = '0;
    end else begin
      case (state_r)
        ST_DISARMED: begin
          if (arm_rise_r) begin
            state_next_s = ST_EXIT_WAIT;
            timer_next_s = TW'(EXIT_CYC - 1);
          end else begin
            state_next_s = ST_DISARMED;
          end
        end
        ST_EXIT_WAIT: begin
          if (timer_r == '0) begin
            state_next_s = ST_ARMED;
          end else begin
            timer_next_s = timer_r - TW'(1);
          end
        end
        ST_ARMED: begin
          if (sensor_deb_s) begin
            state_next_s = ST_ENTRY_WAIT;
            timer_next_s = TW'(ENTRY_CYC - 1);
          end else begin
            state_next_s = ST_ARMED;
          end
        end
        ST_ENTRY_WAIT: begin
          if (timer_r == '0) begin
            state_next_s = ST_ALARM;
          end else begin
            timer_next_s = timer_r - TW'(1);
          end
        end
        ST_ALARM: begin
          state_next_s = ST_ALARM;
        end
        default: begin
          state_next_s = ST_DISARMED;
          timer_next_s = '0;
        end
      endcase
    end
  end

  // State, timer and output registers; outputs are decoded from the next state so they
  // change on the same edge as the state register and never see the inputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_DISARMED;
      timer_r       <= '0;
      alarm_data    <= 1'b0;
      armed         <= 1'b0;
      entry_pending <= 1'b0;
      state_o       <= 3'd0;
    end else begin
      state_r       <= state_next_s;
      timer_r       <= timer_next_s;
      alarm_data    <= (state_next_s == ST_ALARM);
      armed         <= state_is_armed(state_next_s);
      entry_pending <= (state_next_s == ST_ENTRY_WAIT);
      state_o       <= state_next_s;
    end
  end

endmodule

// File: tb/tb_alarm_trigger_ctrl.sv
// Directed bench for alarm_trigger_ctrl with DEBOUNCE_CYC=4, EXIT_CYC=16, ENTRY_CYC=8.
module tb_alarm_trigger_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sensor_in;
  logic       arm_btn;
  logic       disarm_btn;
  logic       alarm_data;
  logic       armed;
  logic       entry_pending;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  alarm_trigger_ctrl #(
    .DEBOUNCE_CYC(4), .EXIT_CYC(16), .ENTRY_CYC(8), .TW(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sensor_in(sensor_in), .arm_btn(arm_btn),
    .disarm_btn(disarm_btn), .alarm_data(alarm_data), .armed(armed),
    .entry_pending(entry_pending), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a disarm press and leave everything released and idle.
  task automatic return_to_idle(input string name);
    sensor_in = 1'b0; arm_btn = 1'b0; disarm_btn = 1'b1;
    cyc(8);
    disarm_btn = 1'b0;
    cyc(12);
    checks++;
    if (state_o !== 3'd0 || alarm_data !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: state=%0d alarm=%0b required state=0 alarm=0", name, state_o, alarm_data);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sensor_in = 1'b0; arm_btn = 1'b0; disarm_btn = 1'b0;
    cyc(3);
    checks++;
    if ({alarm_data, armed, entry_pending, state_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 000000", {alarm_data, armed, entry_pending, state_o});
    end
    rst_n = 1'b1;
    cyc(10);
    checks++;
    if (state_o !== 3'd0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: state=%0d armed=%0b required 0 0", state_o, armed);
    end
  endtask

  task automatic test_full_path;
    int bad;
    arm_btn = 1'b1;
    cyc(7);
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL full_pre_arm: state=%0d required 0", state_o); end
    cyc(1);
    checks++;
    if (state_o !== 3'd1 || armed !== 1'b1) begin
      errors++; $display("FAIL full_exit_wait: state=%0d armed=%0b required 1 1", state_o, armed);
    end
    arm_btn = 1'b0;
    cyc(15);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL full_exit_last: state=%0d required 1", state_o); end
    cyc(1);
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL full_armed: state=%0d required 2", state_o); end
    sensor_in = 1'b1;
    cyc(6);
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL full_pre_entry: state=%0d required 2", state_o); end
    cyc(1);
    checks++;
    if (state_o !== 3'd3 || entry_pending !== 1'b1 || armed !== 1'b1) begin
      errors++; $display("FAIL full_entry: state=%0d pending=%0b armed=%0b required 3 1 1", state_o, entry_pending, armed);
    end
    sensor_in = 1'b0;
    cyc(7);
    checks++;
    if (state_o !== 3'd3 || alarm_data !== 1'b0) begin
      errors++; $display("FAIL full_entry_last: state=%0d alarm=%0b required 3 0", state_o, alarm_data);
    end
    cyc(1);
    checks++;
    if (state_o !== 3'd4 || alarm_data !== 1'b1 || entry_pending !== 1'b0) begin
      errors++; $display("FAIL full_alarm: state=%0d alarm=%0b pending=%0b required 4 1 0", state_o, alarm_data, entry_pending);
    end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1);
      if (alarm_data !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL full_alarm_hold: drop_cycles=%0d required 0", bad); end
    disarm_btn = 1'b1;
    cyc(7);
    checks++;
    if (alarm_data !== 1'b1) begin errors++; $display("FAIL full_pre_disarm: alarm=%0b required 1", alarm_data); end
    cyc(1);
    checks++;
    if (alarm_data !== 1'b0 || state_o !== 3'd0 || armed !== 1'b0) begin
      errors++; $display("FAIL full_disarm: alarm=%0b state=%0d armed=%0b required 0 0 0", alarm_data, state_o, armed);
    end
    disarm_btn = 1'b0;
    cyc(12);
  endtask

  task automatic test_bounce;
    int bad;
    bad = 0;
    for (int p = 0; p < 10; p++) begin
      arm_btn = 1'b1;
      cyc(3);
      if (state_o !== 3'd0) bad++;
      arm_btn = 1'b0;
      cyc(2);
      if (state_o !== 3'd0) bad++;
    end
    cyc(10);
    checks++;
    if (bad !== 0 || state_o !== 3'd0) begin
      errors++; $display("FAIL bounce_reject: bad=%0d state=%0d required 0 0", bad, state_o);
    end
    arm_btn = 1'b1;
    cyc(6);
    arm_btn = 1'b0;
    cyc(1);
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL bounce_pre_arm: state=%0d required 0", state_o); end
    cyc(1);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL bounce_arm: state=%0d required 1", state_o); end
    return_to_idle("bounce");
  endtask

  task automatic test_sensor_in_exit;
    int bad;
    arm_btn = 1'b1;
    cyc(8);
    arm_btn = 1'b0;
    sensor_in = 1'b1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (state_o !== 3'd1) bad++;
      if (i < 15) cyc(1);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL sensor_exit_hold: bad_cycles=%0d required 0", bad); end
    cyc(1);
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL sensor_exit_armed: state=%0d required 2", state_o); end
    cyc(1);
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL sensor_exit_entry: state=%0d required 3", state_o); end
    return_to_idle("sensor_exit");
  endtask

  task automatic test_simultaneous;
    int seen_alarm;
    arm_btn = 1'b1; sensor_in = 1'b1;
    cyc(8);
    arm_btn = 1'b0;
    cyc(17);
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL simul_entry: state=%0d required 3", state_o); end
    disarm_btn = 1'b1;
    seen_alarm = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (alarm_data !== 1'b0) seen_alarm++;
      if (i == 6) begin
        checks++;
        if (state_o !== 3'd3) begin errors++; $display("FAIL simul_last_entry: state=%0d required 3", state_o); end
      end
    end
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL simul_disarm: state=%0d required 0", state_o); end
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (alarm_data !== 1'b0) seen_alarm++;
    end
    checks++;
    if (seen_alarm !== 0) begin errors++; $display("FAIL simul_no_alarm: alarm_cycles=%0d required 0", seen_alarm); end
    return_to_idle("simul");
  endtask

  task automatic test_held_arm;
    int bad;
    arm_btn = 1'b1;
    cyc(8);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL held_exit: state=%0d required 1", state_o); end
    cyc(2);
    disarm_btn = 1'b1;
    cyc(8);
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL held_disarm: state=%0d required 0", state_o); end
    disarm_btn = 1'b0;
    bad = 0;
    for (int i = 0; i < 82; i++) begin
      cyc(1);
      if (state_o !== 3'd0) bad++;
    end
    arm_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (state_o !== 3'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL held_no_rearm: bad_cycles=%0d required 0", bad); end
    arm_btn = 1'b1;
    cyc(8);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL held_rearm: state=%0d required 1", state_o); end
    return_to_idle("held");
  endtask

  task automatic test_reset_mid_entry;
    arm_btn = 1'b1; sensor_in = 1'b1;
    cyc(8);
    arm_btn = 1'b0;
    cyc(19);
    checks++;
    if (state_o !== 3'd3 || entry_pending !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: state=%0d pending=%0b required 3 1", state_o, entry_pending);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({alarm_data, armed, entry_pending, state_o} !== 6'b0) begin
      errors++; $display("FAIL rst_mid_async: got %b required 000000", {alarm_data, armed, entry_pending, state_o});
    end
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    checks++;
    if (state_o !== 3'd0 || armed !== 1'b0 || alarm_data !== 1'b0) begin
      errors++; $display("FAIL rst_mid_no_arm: state=%0d armed=%0b alarm=%0b required 0 0 0", state_o, armed, alarm_data);
    end
    arm_btn = 1'b1;
    cyc(8);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL rst_mid_rearm: state=%0d required 1", state_o); end
    return_to_idle("rst_mid");
  endtask

  initial begin
    test_reset();
    test_full_path();
    test_bounce();
    test_sensor_in_exit();
    test_simultaneous();
    test_held_arm();
    test_reset_mid_entry();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_trigger_ctrl.md
# alarm_trigger_ctrl

Arming/trigger controller that produces the `data` level consumed by the alarm output driver (light/buzzer blinker). It debounces a raw intrusion sensor and arm/disarm push-buttons, runs an exit-delay / armed / entry-delay state machine, and holds `alarm_data` high from expiry of the entry delay until an explicit disarm. It sits between the board inputs and the alarm driver in the anti-impersonation top level.

## Interface
Parameters:
- `DEBOUNCE_CYC`, 500_000: stable cycles needed to accept an input change (10 ms at 50 MHz); ≥1.
- `EXIT_CYC`, 250_000_000: exit delay in cycles after arming (5 s); ≥1.
- `ENTRY_CYC`, 500_000_000: entry delay in cycles after intrusion (10 s); ≥1.
- `TW`, 29: timer width; must hold max(EXIT_CYC, ENTRY_CYC)-1.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sensor_in` in 1: raw intrusion sensor, asynchronous, 1 = intrusion.
- `arm_btn` in 1: raw arm push-button, asynchronous, 1 = pressed.
- `disarm_btn` in 1: raw disarm push-button, asynchronous, 1 = pressed.
- `alarm_data` out 1: to alarm driver `data`; 1 only in ALARM.
- `armed` out 1: 1 in EXIT_WAIT, ARMED, ENTRY_WAIT, ALARM.
- `entry_pending` out 1: 1 only in ENTRY_WAIT (warning LED).
- `state_o` out 3: current state encoding, for debug/LEDs.

## Operation
- Each raw input: 2-FF synchronizer, then debouncer. Debounced value takes the synchronized value after it has differed from the current debounced value for DEBOUNCE_CYC consecutive cycles; any bounce back restarts the count.
- Buttons: rising-edge detect on debounced value (registered previous value); one-cycle `arm_rise` / `disarm_rise`. Held button produces one pulse.
- Sensor: level-sensitive (debounced level).
- States: DISARMED(0), EXIT_WAIT(1), ARMED(2), ENTRY_WAIT(3), ALARM(4).
  - DISARMED: `arm_rise` -> EXIT_WAIT, timer ← EXIT_CYC-1.
  - EXIT_WAIT: timer==0 -> ARMED; else decrement. Sensor ignored.
  - ARMED: sensor high -> ENTRY_WAIT, timer ← ENTRY_CYC-1. Sensor already high on entry to ARMED -> ENTRY_WAIT the next cycle.
  - ENTRY_WAIT: timer==0 -> ALARM; else decrement. Sensor return to low does not cancel.
  - ALARM: stays until disarm; sensor ignored.
- `disarm_rise` in any state -> DISARMED, with priority over every other transition including same-cycle timer expiry and `arm_rise`.
- `arm_rise` outside DISARMED ignored.
- Outputs are pure decodes of the state register (no combinational path from inputs).
- Reset (async assert, any time incl. mid-delay or in ALARM): state DISARMED, timer 0, synchronizers and debounced values 0, edge registers 0; `alarm_data`=0, `armed`=0, `entry_pending`=0, `state_o`=0. Release synchronous to `clk`.

## Timing
- Raw input step (clean) -> debounced change: 2 + DEBOUNCE_CYC cycles.
- Debounced button rise -> new state visible: 1 cycle (edge register) + 1 cycle (state register). Total raw press -> `state_o` change: DEBOUNCE_CYC + 4 cycles.
- EXIT_WAIT and ENTRY_WAIT each occupy exactly EXIT_CYC / ENTRY_CYC cycles.
- Debounced sensor high in ARMED -> ENTRY_WAIT: 1 cycle.
- Timer: unsigned TW bits, down-count, never wraps (only decremented when nonzero).

## Structure
- Shared package `alarm_pkg`: state encoding constants (3-bit) and default cycle counts, shared with the alarm driver top.
- Sub-module `input_debounce` (synchronizer + stable-count debouncer, parameter DEBOUNCE_CYC), instantiated three times. FSM and timer live in `alarm_trigger_ctrl`.

## Test plan
Bench parameters: DEBOUNCE_CYC=4, EXIT_CYC=16, ENTRY_CYC=8.
- Reset: assert `rst_n`=0 mid-ENTRY_WAIT -> all outputs 0 immediately; after release, `arm_btn` needed before any arming.
- Full alarm path: arm press -> EXIT_WAIT 8 cycles later, ARMED after 16 more; sensor high -> ENTRY_WAIT after 2+4+1 cycles; `alarm_data`=1 after exactly 8 ENTRY_WAIT cycles; stays 1 for 1000 cycles until disarm; disarm -> `alarm_data`=0, state 0.
- Bounce rejection: `arm_btn` pulses of 3 cycles high/2 low repeated 10× -> state stays DISARMED; then steady 6-cycle press -> exactly one transition to EXIT_WAIT.
- Sensor in EXIT_WAIT held high -> no ENTRY_WAIT during exit; ENTRY_WAIT entered 1 cycle after ARMED.
- Simultaneous: disarm rise on the cycle ENTRY_WAIT timer hits 0 -> DISARMED, `alarm_data` never 1.
- Held arm button 100 cycles, disarm mid-EXIT_WAIT -> DISARMED and no re-arm until arm released and pressed again.
